mul4x16_seq_ctrl: RTL and testbench



---
 rtl/mul4x16_seq_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mul4x16_seq_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul4x16_seq_ctrl.sv
// Issue/collect sequencer for the 4x16 shift-add multiplier: takes operand pairs,
// runs the st/done handshake, returns products. Optional macro MSEQ_ACC_EN accumulates groups.
`timescale 1ns/1ps

module mul4x16_seq_ctrl #(
  parameter int TIMEOUT   = 32,
  parameter int DRAIN_CYC = 12,
  parameter int ACC_W     = 24,
`ifdef MSEQ_ACC_EN
  localparam int RES_W    = ACC_W
`else
  localparam int RES_W    = 20
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_mcand,
  input  logic [15:0]      op_mult,
  input  logic             op_last,
  output logic             mul_st,
  output logic [3:0]       mul_mcand,
  output logic [15:0]      mul_mult,
  input  logic             mul_done,
  input  logic [19:0]      mul_product,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RES_W-1:0] res_data,
  output logic             err,
  output logic [2:0]       dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // a valid source holds its data stable until that edge, and ready may depend on state only.

  localparam int CNT_W = $clog2(TIMEOUT + DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    S_DRAIN  = 3'd0,
    S_IDLE   = 3'd1,
    S_RUN    = 3'd2,
    S_SETTLE = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               st_q, st_d;
  logic [3:0]         mcand_q, mcand_d;
  logic [15:0]        mult_q, mult_d;
  logic               res_valid_q, res_valid_d;
  logic [RES_W-1:0]   res_data_q, res_data_d;
  logic               err_q, err_d;

`ifdef MSEQ_ACC_EN
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               last_q, last_d;
  logic [ACC_W-1:0]   acc_sum;
  assign acc_sum = acc_q + ACC_W'(mul_product);
`else
  logic               unused_op_last;
  assign unused_op_last = op_last;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_DRAIN;
      cnt_q       <= '0;
      st_q        <= 1'b0;
      mcand_q     <= '0;
      mult_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
`ifdef MSEQ_ACC_EN
      acc_q       <= '0;
      last_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      st_q        <= st_d;
      mcand_q     <= mcand_d;
      mult_q      <= mult_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
`ifdef MSEQ_ACC_EN
      acc_q       <= acc_d;
      last_q      <= last_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    st_d        = st_q;
    mcand_d     = mcand_q;
    mult_d      = mult_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    err_d       = err_q;
`ifdef MSEQ_ACC_EN
    acc_d       = acc_q;
    last_d      = last_q;
`endif
    unique case (state_q)
      S_DRAIN: begin
        st_d = 1'b0;
        if (cnt_q == CNT_W'(DRAIN_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (op_valid) begin
          mcand_d = op_mcand;
          mult_d  = op_mult;
          st_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef MSEQ_ACC_EN
          last_d  = op_last;
`endif
        end
      end
      S_RUN: begin
        if (mul_done) begin
          st_d    = 1'b0;
          state_d = S_SETTLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Watchdog abort: no result, then drain so the multiplier returns to idle.
          st_d    = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_DRAIN;
`ifdef MSEQ_ACC_EN
          acc_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SETTLE: begin
        // Product register became valid at the end of the first done cycle.
`ifdef MSEQ_ACC_EN
        acc_d = acc_sum;
        if (last_q) begin
          res_data_d  = acc_sum;
          res_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          state_d = S_IDLE;
        end
`else
        res_data_d  = mul_product;
        res_valid_d = 1'b1;
        state_d     = S_OUT;
`endif
      end
      S_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
`ifdef MSEQ_ACC_EN
          acc_d       = '0;
`endif
        end
      end
      default: begin
        st_d    = 1'b0;
        cnt_d   = '0;
        state_d = S_DRAIN;
      end
    endcase
  end

  assign op_ready    = (state_q == S_IDLE);
  assign mul_st      = st_q;
  assign mul_mcand   = mcand_q;
  assign mul_mult    = mult_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mul4x16_seq_ctrl.sv
// Bench for mul4x16_seq_ctrl with a behavioural 4x16 multiplier stub and a result queue.
`timescale 1ns/1ps

module tb_mul4x16_seq_ctrl;
`ifdef MSEQ_ACC_EN
  localparam int RW = 24;
`else
  localparam int RW = 20;
`endif
  localparam int TIMEOUT   = 32;
  localparam int DRAIN_CYC = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_last = 1'b0;
  logic          res_ready = 1'b0;
  logic [3:0]    op_mcand = '0;
  logic [15:0]   op_mult = '0;
  logic          op_ready, mul_st, res_valid, err, mul_done;
  logic [3:0]    mul_mcand;
  logic [15:0]   mul_mult;
  logic [19:0]   mul_product;
  logic [RW-1:0] res_data;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] model_acc = '0;
  logic stub_never_done = 1'b0;
  logic stale_done = 1'b0;

  mul4x16_seq_ctrl #(.TIMEOUT(TIMEOUT), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_mcand(op_mcand), .op_mult(op_mult),
    .op_last(op_last),
    .mul_st(mul_st), .mul_mcand(mul_mcand), .mul_mult(mul_mult),
    .mul_done(mul_done), .mul_product(mul_product),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err(err), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Multiplier stub: done rises 10 cycles after st is first seen, product is junk
  // until the end of the first done cycle, and everything clears when st drops.
  int          m_cnt = 0;
  logic        m_done = 1'b0;
  logic [19:0] m_prod = '0;
  always @(posedge clk) begin
    if (!mul_st) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
    end else begin
      if (m_cnt == 0) m_prod <= 20'($urandom);
      if (!m_done && !stub_never_done) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt == 9) m_done <= 1'b1;
      end
      if (m_done) m_prod <= 20'(mul_mcand) * 20'(mul_mult);
    end
  end
  assign mul_done    = m_done | stale_done;
  assign mul_product = m_prod;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (op_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input logic [3:0] a, input logic [15:0] b, input int hold);
    int n;
    int t;
    bit bad;
    logic [RW-1:0] exp;
    wait_ready(n);
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL op_ready_wait: op_ready=%b after %0d cycles, required 1", op_ready, n);
      return;
    end
    res_ready = 1'b0;
    op_valid = 1'b1;
    op_mcand = a;
    op_mult  = b;
    op_last  = 1'b1;
    exp_q.push_back(model_acc + RW'(a) * RW'(b));
    tick();
    op_valid = 1'b0;
    op_mcand = 4'($urandom);
    op_mult  = 16'($urandom);
    op_last  = 1'($urandom);
    checks++;
    if (mul_st !== 1'b1 || mul_mcand !== a || mul_mult !== b) begin
      errors++;
      $display("FAIL issue: st=%b mcand=%0d mult=%0d, required 1 %0d %0d", mul_st, mul_mcand, mul_mult, a, b);
    end
    t = 1;
    bad = 1'b0;
    while (res_valid !== 1'b1 && t < 60) begin
      if (mul_st !== (t <= 11)) bad = 1'b1;
      if (op_ready !== 1'b0 || mul_mcand !== a || mul_mult !== b) bad = 1'b1;
      tick();
      t++;
    end
    checks++;
    if (t !== 13) begin
      errors++;
      $display("FAIL result_latency: res_valid at cycle %0d, required 13", t);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL run_shape: st/operand/op_ready pattern wrong during run (bad=%b), required 0", bad);
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    bad = 1'b0;
    repeat (hold) begin
      if (res_valid !== 1'b1 || res_data !== exp || op_ready !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (res_data !== exp) begin
      errors++;
      $display("FAIL result_data: got 0x%0h, required 0x%0h", res_data, exp);
    end
    if (hold > 0) begin
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL result_hold: result changed while stalled (bad=%b), required 0", bad);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || op_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept: res_valid=%b op_ready=%b, required 0 1", res_valid, op_ready);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({op_ready, mul_st, res_valid, err} !== 4'b0 || mul_mcand !== '0 || mul_mult !== '0 || res_data !== '0) begin
      errors++;
      $display("FAIL %s: rdy=%b st=%b rv=%b err=%b mc=%0d ml=%0d rd=%0d, required all 0",
               tag, op_ready, mul_st, res_valid, err, mul_mcand, mul_mult, res_data);
    end
  endtask

  task automatic check_drain(input string tag);
    int n;
    wait_ready(n);
    checks++;
    if (n !== DRAIN_CYC) begin
      errors++;
      $display("FAIL %s: op_ready low for %0d cycles, required %0d", tag, n, DRAIN_CYC);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    check_reset_values("reset_values");
    rst = 1'b1;
    check_drain("reset_drain");
  endtask

  task automatic test_basic();
    run_op(4'd7, 16'h1234, 0);
    run_op(4'd15, 16'hFFFF, 5);
    checks++;
    if (res_data !== RW'(20'hEFFF1)) begin
      errors++;
      $display("FAIL max_product: got 0x%0h, required 0xEFFF1", res_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  a [3];
    logic [15:0] b [3];
    int acc_t [3];
    int res_t [3];
    int ni = 0;
    int nr = 0;
    a = '{4'd0, 4'd1, 4'd6};
    b = '{16'($urandom), 16'hFFFF, 16'd7};
    acc_t = '{0, 0, 0};
    res_t = '{0, 0, 0};
    res_ready = 1'b1;
    for (int c = 0; c < 80 && nr < 3; c++) begin
      if (res_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0 || res_data !== exp_q[0]) begin
          errors++;
          $display("FAIL b2b_data: got 0x%0h, required 0x%0h", res_data, (exp_q.size() > 0) ? exp_q[0] : '0);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        res_t[nr] = c;
        nr++;
      end
      if (op_ready === 1'b1 && ni < 3) begin
        op_valid = 1'b1;
        op_mcand = a[ni];
        op_mult  = b[ni];
        op_last  = 1'b1;
        exp_q.push_back(RW'(a[ni]) * RW'(b[ni]));
        acc_t[ni] = c;
        ni++;
      end else begin
        op_valid = 1'b0;
      end
      tick();
    end
    op_valid = 1'b0;
    res_ready = 1'b0;
    checks++;
    if (nr !== 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, required 3", nr);
    end
    checks++;
    if (acc_t[1] - acc_t[0] !== 14 || acc_t[2] - acc_t[1] !== 14 || res_t[0] - acc_t[0] !== 13) begin
      errors++;
      $display("FAIL b2b_spacing: accepts %0d %0d %0d result0 %0d, required 14-cycle spacing and +13",
               acc_t[0], acc_t[1], acc_t[2], res_t[0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_op(4'($urandom), 16'($urandom), $urandom_range(0, 3));
  endtask

  task automatic test_timeout();
    int n;
    int t;
    bit seen = 1'b0;
    wait_ready(n);
    stub_never_done = 1'b1;
    op_valid = 1'b1;
    op_mcand = 4'($urandom_range(1, 15));
    op_mult  = 16'($urandom);
    op_last  = 1'b1;
    tick();
    op_valid = 1'b0;
    t = 1;
    while (err !== 1'b1 && t < 100) begin
      if (res_valid === 1'b1) seen = 1'b1;
      tick();
      t++;
    end
    checks++;
    if (t !== TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_cycle: err rose at cycle %0d, required %0d", t, TIMEOUT + 1);
    end
    checks++;
    if (seen || res_valid !== 1'b0 || mul_st !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort: res_seen=%b res_valid=%b st=%b, required 0 0 0", seen, res_valid, mul_st);
    end
    stub_never_done = 1'b0;
    check_drain("timeout_drain");
    run_op(4'($urandom), 16'($urandom), 1);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%b, required 1", err);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    bit bad = 1'b0;
    wait_ready(n);
    op_valid = 1'b1;
    op_mcand = 4'($urandom_range(1, 15));
    op_mult  = 16'($urandom_range(1, 65535));
    tick();
    op_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    check_reset_values("reset_mid_run");
    rst = 1'b1;
    stale_done = 1'b1;
    check_drain("reset_mid_run_drain");
    repeat (5) begin
      if (mul_st !== 1'b0 || res_valid !== 1'b0 || op_ready !== 1'b1) bad = 1'b1;
      tick();
    end
    stale_done = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stale_done: stale done changed idle outputs (bad=%b), required 0", bad);
    end
    run_op(4'($urandom), 16'($urandom), 0);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL result_queue: %0d results left over, required 0", exp_q.size());
    end
  endtask

`ifdef MSEQ_ACC_EN
  task automatic test_accumulate();
    logic [3:0]  a [2];
    logic [15:0] b [2];
    int n;
    int t;
    bit seen;
    a = '{4'd2, 4'd3};
    b = '{16'd100, 16'd1000};
    model_acc = '0;
    for (int i = 0; i < 2; i++) begin
      wait_ready(n);
      op_valid = 1'b1;
      op_mcand = a[i];
      op_mult  = b[i];
      op_last  = 1'b0;
      model_acc = model_acc + RW'(a[i]) * RW'(b[i]);
      tick();
      op_valid = 1'b0;
      t = 1;
      seen = 1'b0;
      while (op_ready !== 1'b1 && t < 60) begin
        if (res_valid === 1'b1) seen = 1'b1;
        tick();
        t++;
      end
      checks++;
      if (seen || t !== 13) begin
        errors++;
        $display("FAIL acc_partial: res_seen=%b back in idle at %0d, required 0 at 13", seen, t);
      end
    end
    run_op(4'd1, 16'd5, 2);
    model_acc = '0;
    checks++;
    if (res_data !== RW'(3205)) begin
      errors++;
      $display("FAIL acc_sum: got %0d, required 3205", res_data);
    end
    run_op(4'd3, 16'd3, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_random();
`ifdef MSEQ_ACC_EN
    test_accumulate();
`endif
    test_timeout();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule
